// File: rtl/cache_arb_types_pkg.sv
// Shared types and default geometry for the I/D-cache to physical-memory arbiter.
package cache_arb_types_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int LINE_WIDTH_DEF = 256;
  localparam int OFFSET_BITS    = $clog2(LINE_WIDTH_DEF / 8);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RECOVER
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one memory port.
// ARB_ROUND_ROBIN_EN: contested grants go to the requestor that was not served last.
module cache_arbiter
  import cache_arb_types_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LINE_WIDTH = LINE_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_read,
  input  logic [ADDR_WIDTH-1:0] imem_address,
  output logic [LINE_WIDTH-1:0] imem_rdata,
  output logic                  imem_resp,
  input  logic                  dmem_read,
  input  logic                  dmem_write,
  input  logic [ADDR_WIDTH-1:0] dmem_address,
  input  logic [LINE_WIDTH-1:0] dmem_wdata,
  output logic [LINE_WIDTH-1:0] dmem_rdata,
  output logic                  dmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

  arb_state_t            state, state_next;
  arb_owner_t            last_owner;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  write_q;
  logic                  i_req, d_req, grant_i, grant_d;

  always_comb begin
    i_req = imem_read;
    d_req = dmem_read || dmem_write;
`ifdef ARB_ROUND_ROBIN_EN
    grant_d = d_req && (!i_req || last_owner == OWN_I);
`else
    grant_d = d_req;
`endif
    grant_i = i_req && !grant_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_owner <= OWN_I;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && (grant_i || grant_d)) begin
        addr_q  <= (grant_d ? dmem_address : imem_address) & ALIGN_MASK;
        wdata_q <= grant_d ? dmem_wdata : '0;
        // a simultaneous read+write from the D side is serviced as a writeback
        write_q <= grant_d && dmem_write;
      end
      if (state == SERVE_I && pmem_resp) last_owner <= OWN_I;
      if (state == SERVE_D && pmem_resp) last_owner <= OWN_D;
    end
  end

  always_comb begin
    state_next   = state;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    imem_resp    = 1'b0;
    imem_rdata   = '0;
    dmem_resp    = 1'b0;
    dmem_rdata   = '0;
    case (state)
      IDLE: begin
        if (grant_d)      state_next = SERVE_D;
        else if (grant_i) state_next = SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        pmem_read    = !write_q;
        pmem_write   = write_q;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        if (pmem_resp) begin
          state_next = RECOVER;
          if (state == SERVE_I) begin
            imem_resp  = 1'b1;
            imem_rdata = pmem_rdata;
          end else begin
            dmem_resp  = 1'b1;
            dmem_rdata = pmem_rdata;
          end
        end
      end
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifndef SYNTHESIS
  rw_overlap: assert property (@(posedge clk) disable iff (!rst) !(dmem_read && dmem_write))
    else $warning("dmem_read and dmem_write both high, serviced as a writeback");
  owner_i: assert property (@(posedge clk) disable iff (!rst) imem_resp |=> last_owner == OWN_I)
    else $error("last_owner not updated after I-side completion");
  owner_d: assert property (@(posedge clk) disable iff (!rst) dmem_resp |=> last_owner == OWN_D)
    else $error("last_owner not updated after D-side completion");
`endif

endmodule
